// File: rtl/bawsss_mmio_timer_if.sv
// CPU data-memory bus as seen by the timer: store strobe, byte address, store data,
// plus the read data and window-hit returned to the top-level read mux.
interface bawsss_mmio_timer_if;
  logic        memWrite;
  logic [15:0] address;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        hit;

  modport master (output memWrite, address, writeData, input readData, hit);
  modport slave  (input memWrite, address, writeData, output readData, hit);
endinterface

// File: rtl/bawsss_mmio_timer.sv
// Memory-mapped prescaled 16-bit timer with compare match, auto-reload and irq.
// Define BAWSSS_TIMER_CAPTURE_EN to build the capture_in synchronizer and CAPTURE register.
module bawsss_mmio_timer #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bawsss_mmio_timer_if.slave    bus,
  output logic                  irq,
  input  logic                  capture_in
);

  logic                  en, auto_reload, irq_en;
  logic [PRESCALE_W-1:0] prescale, presc;
  logic [15:0]           count, compare, capture;
  logic                  match, capt;
  logic [2:0]            sel;
  logic                  wr, wr_ctrl, wr_count, wr_compare, wr_status;
  logic                  tick, match_evt;
  logic [15:0]           ctrl_rd;

  assign bus.hit    = (bus.address[15:4] == BASE_ADDR[15:4]);
  assign sel        = bus.address[3:1];
  assign wr         = bus.memWrite & bus.hit;
  assign wr_ctrl    = wr && (sel == 3'd0);
  assign wr_count   = wr && (sel == 3'd1);
  assign wr_compare = wr && (sel == 3'd2);
  assign wr_status  = wr && (sel == 3'd3);

  assign tick      = en && (presc == prescale);
  // A CPU store to COUNT suppresses both the increment and the compare for that cycle.
  assign match_evt = tick && !wr_count && (count == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
    end else if (wr_ctrl) begin
      en          <= bus.writeData[0];
      auto_reload <= bus.writeData[1];
      irq_en      <= bus.writeData[2];
      prescale    <= bus.writeData[8 +: PRESCALE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          presc <= '0;
    else if (wr_ctrl) presc <= '0;
    else if (en)      presc <= tick ? '0 : presc + PRESCALE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 16'h0000;
      compare <= 16'hFFFF;
    end else begin
      if (wr_count)       count <= bus.writeData;
      else if (match_evt) count <= auto_reload ? 16'h0000 : count + 16'd1;
      else if (tick)      count <= count + 16'd1;
      if (wr_compare)     compare <= bus.writeData;
    end
  end

  // Hardware set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                match <= 1'b0;
    else if (match_evt)                     match <= 1'b1;
    else if (wr_status && bus.writeData[0]) match <= 1'b0;
  end

`ifdef BAWSSS_TIMER_CAPTURE_EN
  logic sync1, sync2, sync3, cap_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= capture_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign cap_rise = sync2 & ~sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capture <= 16'h0000;
      capt    <= 1'b0;
    end else begin
      if (cap_rise) capture <= count;
      if (cap_rise)                                capt <= 1'b1;
      else if (wr_status && bus.writeData[1])      capt <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture_in;
  assign capture        = 16'h0000;
  assign capt           = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.address[0], bus.writeData[7:3]};

  assign irq = match & irq_en;

  always_comb begin
    ctrl_rd                   = 16'h0000;
    ctrl_rd[8 +: PRESCALE_W]  = prescale;
    ctrl_rd[2:0]              = {irq_en, auto_reload, en};
  end

  always_comb begin
    bus.readData = 16'h0000;
    if (bus.hit) begin
      case (sel)
        3'd0:    bus.readData = ctrl_rd;
        3'd1:    bus.readData = count;
        3'd2:    bus.readData = compare;
        3'd3:    bus.readData = {14'h0000, capt, match};
        3'd4:    bus.readData = capture;
        default: bus.readData = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_bawsss_mmio_timer.sv
// Randomised and directed bench for bawsss_mmio_timer against a behavioural register model.
module tb_bawsss_mmio_timer;

  logic clk = 1'b0;
  logic rst;
  logic irq;
  logic capture_in;

  bawsss_mmio_timer_if bus ();

  bawsss_mmio_timer #(.BASE_ADDR(16'hFF00), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .irq        (irq),
    .capture_in (capture_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_en, m_ar, m_ie;
  logic [7:0]  m_ps;
  int          m_pre;
  logic [15:0] m_count, m_cmp, m_capture;
  bit          m_match, m_capt;
  bit          pin_hist [0:2];

`ifdef BAWSSS_TIMER_CAPTURE_EN
  localparam bit CAP_ON = 1'b1;
`else
  localparam bit CAP_ON = 1'b0;
`endif

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_ps = 8'h00; m_pre = 0;
    m_count = 16'h0000; m_cmp = 16'hFFFF; m_capture = 16'h0000;
    m_match = 0; m_capt = 0;
    for (int i = 0; i < 3; i++) pin_hist[i] = 0;
  endtask

  function automatic logic [15:0] m_read(logic [15:0] a);
    if (a[15:4] != 12'hFF0) return 16'h0000;
    case (a[3:1])
      3'd0:    return {m_ps, 5'b00000, m_ie, m_ar, m_en};
      3'd1:    return m_count;
      3'd2:    return m_cmp;
      3'd3:    return {14'h0000, m_capt, m_match};
      3'd4:    return m_capture;
      default: return 16'h0000;
    endcase
  endfunction

  // One rising edge of the timer, computed from the pre-edge state.
  task automatic m_edge(bit we, logic [15:0] a, logic [15:0] d, bit pin);
    bit          w, tick, matched, rise;
    logic [15:0] n_count;
    int          s;
    w       = we && (a[15:4] == 12'hFF0);
    s       = int'(a[3:1]);
    tick    = m_en && (m_pre == int'(m_ps));
    rise    = pin_hist[1] && !pin_hist[2];
    matched = 0;
    n_count = m_count;
    if (w && s == 1)      n_count = d;
    else if (tick) begin
      if (m_count == m_cmp) begin
        matched = 1;
        n_count = m_ar ? 16'h0000 : m_count + 16'd1;
      end else n_count = m_count + 16'd1;
    end
    if (CAP_ON) begin
      if (rise) begin m_capture = m_count; m_capt = 1; end
      else if (w && s == 3 && d[1]) m_capt = 0;
    end
    if (matched) m_match = 1;
    else if (w && s == 3 && d[0]) m_match = 0;
    if (w && s == 0) m_pre = 0;
    else if (m_en) m_pre = tick ? 0 : m_pre + 1;
    m_count = n_count;
    if (w && s == 2) m_cmp = d;
    if (w && s == 0) begin
      m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_ps = d[15:8];
    end
    pin_hist[2] = pin_hist[1];
    pin_hist[1] = pin_hist[0];
    pin_hist[0] = pin;
  endtask

  // Drive one bus cycle, check combinational outputs against the model, then clock it.
  task automatic cycle(bit we, logic [15:0] a, logic [15:0] d);
    bus.memWrite  = we;
    bus.address   = a;
    bus.writeData = d;
    #1;
    check("readData", bus.readData, m_read(a));
    check("hit", bus.hit, a[15:4] == 12'hFF0);
    check("irq", irq, m_match & m_ie);
    @(posedge clk);
    m_edge(we, a, d, capture_in);
    #1;
  endtask

  task automatic peek(string tag, logic [15:0] a, logic [15:0] exp);
    bus.memWrite = 1'b0;
    bus.address  = a;
    #1;
    check(tag, bus.readData, exp);
  endtask

  // Asynchronous reset asserted mid-cycle; registers are read while it is held.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    m_reset();
    peek("rst_compare", 16'hFF04, 16'hFFFF);
    peek("rst_ctrl",    16'hFF00, 16'h0000);
    peek("rst_count",   16'hFF02, 16'h0000);
    peek("rst_status",  16'hFF06, 16'h0000);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    m_edge(1'b0, bus.address, 16'h0000, capture_in);
    #1;
  endtask

  initial begin
    logic [31:0] u;
    logic [15:0] a, d;
    bit          we;

    rst = 1'b1;
    capture_in = 1'b0;
    bus.memWrite = 1'b0;
    bus.address = 16'h0000;
    bus.writeData = 16'h0000;
    m_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    m_edge(1'b0, 16'h0000, 16'h0000, capture_in);
    #1;

    // Reset while idle, then reads
    cycle(1'b1, 16'hFF04, 16'h1234);
    do_reset();

    // Prescaled count: PRESCALE=3 gives one tick per 4 cycles
    cycle(1'b1, 16'hFF02, 16'h0000);
    cycle(1'b1, 16'hFF00, 16'h0301);
    for (int i = 0; i < 40; i++) cycle(1'b0, 16'hFF02, 16'h0000);
    peek("presc_count", 16'hFF02, 16'd10);
    peek("outside_rd", 16'h1000, 16'h0000);
    check("outside_hit", bus.hit, 1'b0);

    // Match with auto-reload and irq
    cycle(1'b1, 16'hFF04, 16'h0005);
    cycle(1'b1, 16'hFF02, 16'h0000);
    cycle(1'b1, 16'hFF00, 16'h0007);
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'hFF02, 16'h0000);
    peek("ar_status", 16'hFF06, 16'h0001);
    check("ar_irq", irq, 1'b1);
    peek("ar_count", 16'hFF02, 16'h0000);
    cycle(1'b1, 16'hFF06, 16'h0001);
    check("w1c_irq", irq, 1'b0);
    peek("w1c_status", 16'hFF06, 16'h0000);

    // No auto-reload: wrap through FFFF, match on 3 -> 4
    cycle(1'b1, 16'hFF00, 16'h0000);
    cycle(1'b1, 16'hFF04, 16'h0003);
    cycle(1'b1, 16'hFF06, 16'h0001);
    cycle(1'b1, 16'hFF02, 16'hFFFE);
    cycle(1'b1, 16'hFF00, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'hFF02, 16'h0000);
      peek($sformatf("wrap_count%0d", i), 16'hFF02, (i == 0) ? 16'hFFFF : 16'(i - 1));
      peek($sformatf("wrap_match%0d", i), 16'hFF06, (i == 5) ? 16'h0001 : 16'h0000);
    end

    // Collisions: COUNT store on a tick, W1C on a match
    cycle(1'b1, 16'hFF02, 16'h0100);
    peek("coll_count", 16'hFF02, 16'h0100);
    cycle(1'b1, 16'hFF06, 16'h0001);
    cycle(1'b1, 16'hFF04, 16'h0105);
    cycle(1'b1, 16'hFF02, 16'h0105);
    cycle(1'b1, 16'hFF06, 16'h0001);
    peek("coll_match", 16'hFF06, 16'h0001);

    // Capture of free-running COUNT, third edge after the pin rises
    cycle(1'b1, 16'hFF06, 16'h0003);
    cycle(1'b1, 16'hFF02, 16'h0040);
    capture_in = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'hFF08, 16'h0000);
    peek("cap_value", 16'hFF08, CAP_ON ? 16'h0042 : 16'h0000);
    peek("cap_flag", 16'hFF06, CAP_ON ? 16'h0002 : 16'h0000);
    capture_in = 1'b0;

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      u = $urandom;
      we = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 9) != 0) a = 16'hFF00 | 16'($urandom_range(0, 15));
      else a = u[15:0];
      u = $urandom;
      case (a[3:1])
        3'd0:    d = 16'(($urandom_range(0, 3) << 8) | (u & 32'h0000_00F8) | $urandom_range(0, 7));
        3'd1,
        3'd2:    d = 16'($urandom_range(0, 30));
        default: d = u[15:0];
      endcase
      if ($urandom_range(0, 9) == 0) capture_in = ~capture_in;
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle(we, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
